clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Parametrised bank of independent clock dividers and tick generators driven from the board's 50 MHz oscillator. Each channel produces a 50 %-duty divided clock and a one-cycle tick strobe, with its half-period programmable at run time and changed glitch-free. It replaces per-rate fixed divider modules (1 Hz blink, scan-rate, debounce sampling) and sits directly behind the oscillator input, feeding LED, seven-segment and debounce logic.

## Interface
- CNT_W, 28: half-period counter width; CNT_W = 28 covers 1 Hz at 50 MHz.
- NUM_CH, 4: number of divider channels, 1..16.
- RST_HP, 25_000_000: half-period loaded into every channel at reset; 25_000_000 gives 1 Hz.
- CH_W, $clog2(NUM_CH) (minimum 1): channel index width.

- clk_50M  in  1: 50 MHz system clock; all logic on its rising edge.
- rst  in  1: synchronous, active-high reset.
- en  in  NUM_CH: per-channel run enable.
- wr_en  in  1: one-cycle half-period write strobe.
- wr_ch  in  CH_W: channel targeted by wr_en; values ≥ NUM_CH are ignored.
- wr_hp  in  CNT_W: new half-period, in clk_50M cycles.
- clk_out  out  NUM_CH: divided clock per channel; registered.
- tick  out  NUM_CH: one-cycle strobe on each rising transition of clk_out; registered.
- busy  out  NUM_CH: a written half-period is pending and not yet applied.

## Operation
Per-channel state:
- cnt: counter, CNT_W bits.
- hp: active half-period.
- hp_pend: pending half-period.
- pend: pending flag.
- clk_out and tick registers.

Running channel (en = 1, hp ≥ 1):
- cnt counts 0..hp-1.
- When cnt = hp-1 (boundary): cnt wraps to 0 and clk_out toggles.
- If clk_out goes 0→1 at a boundary, tick = 1 for exactly that cycle; tick = 0 otherwise.
- Period is exactly 2·hp cycles; high and low phases are each hp cycles. There is no off-by-one slack.

hp = 0:
- The channel is stopped: clk_out = 0, tick = 0, cnt = 0.

Runtime write (wr_en with valid wr_ch):
- hp_pend ← wr_hp and pend ← 1.
- At the next boundary: hp ← hp_pend, pend ← 0, and the new value governs the half-period that starts there. No shortened or stretched phase results.
- If the channel is idle (en = 0 or hp = 0), the value is applied on the next cycle.
- Write in the same cycle as a boundary: the written value is applied at that boundary.
- Second write before application: the last write wins.

Enable deassert:
- Next cycle: cnt = 0, clk_out = 0, tick = 0. hp is retained.

Enable reassert:
- First cycle of the high phase is the cycle after en rises.
- tick asserts in that cycle, because it is a 0→1 transition.
- clk_out stays high for hp cycles.

Reset:
- Sets hp = RST_HP, cnt = 0, clk_out = 0, tick = 0, pend = 0, busy = 0, on every channel.
- Reset mid-period discards the phase in progress and any pending write.
- After reset deasserts, a channel with en = 1 behaves as on enable reassert.

Channels share no state other than the write port.

## Timing
- All outputs are registered.
- Reset values: clk_out = 0, tick = 0, busy = 0.
- Write latency: busy rises the cycle after wr_en and falls in the cycle the new hp takes effect.
- Enable latency: one cycle from en to a change on clk_out.
- tick coincides with the first high cycle of clk_out.
- Timing closure: the cnt = hp-1 compare is at most CNT_W bits and must meet 50 MHz on Spartan-6 with no pipelining.

## Structure
Shared package clk_div_pkg:
- CNT_W default.
- CLK_HZ = 50_000_000.
- A constant function hp_for_hz(f), returning CLK_HZ/(2·f).

Sub-module clk_div_ch:
- Implements one channel: cnt, hp, hp_pend, pend, clk_out, tick.
- The top level instantiates NUM_CH copies with a generate loop and decodes wr_ch into a per-channel write strobe.

## Test plan
- Reset, then en[0] = 1 with hp written to 3 → clk_out[0] shows 3 high, 3 low, repeating; tick[0] pulses once every 6 cycles, aligned to each rising edge; busy is 0 after application.
- Running at hp = 3, write hp = 5 mid-high-phase → the current high phase stays 3 cycles, the next low phase is 5 cycles, and busy is high until that boundary.
- Write timed exactly on a boundary cycle with hp = 2 → the next phase is 2 cycles; a second write of 4 then 6 within one phase → 6 is applied.
- Write hp = 0 → clk_out held 0 with no ticks; then write hp = 1 → clk_out toggles every cycle and tick pulses every 2 cycles.
- Deassert en mid-high-phase, then reassert → clk_out is 0 one cycle after deassert; after reassert, tick fires on the first high cycle and the full hp-cycle high phase follows. Channels 1..3 are unaffected throughout.
- Assert rst mid-period with a write pending → all outputs are 0 the next cycle and hp = RST_HP. With RST_HP overridden to 10 for simulation, the period measured after reset is 20 cycles.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider bank.
// The bank runs from the 50 MHz board oscillator.
package clk_div_pkg;

  localparam int          CNT_W_DEF = 28;
  localparam int unsigned CLK_HZ    = 50_000_000;

  // Half-period in oscillator cycles for an output frequency of f Hz.
  function automatic int unsigned hp_for_hz(input int unsigned f);
    return CLK_HZ / (2 * f);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, 50 % duty clock, rising-edge tick,
// and a pending half-period register that is only applied on a phase boundary.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int          CNT_W  = CNT_W_DEF,
  parameter int unsigned RST_HP = 25_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_hp_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic [CNT_W-1:0] hp_pend_q, hp_pend_d;
  logic [CNT_W-1:0] nxt_hp;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             run_q, run_d;
  logic             idle, bnd, apply;

  assign idle   = !en_i || (hp_q == '0);
  assign bnd    = run_q && (cnt_q == hp_q - CNT_W'(1));
  // A write landing on the boundary cycle takes precedence over an older pending value.
  assign nxt_hp = wr_i ? wr_hp_i : hp_pend_q;
  assign apply  = wr_i || pend_q;

  always_comb begin
    cnt_d     = cnt_q;
    hp_d      = hp_q;
    hp_pend_d = hp_pend_q;
    pend_d    = pend_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    run_d     = run_q;
    if (idle) begin
      cnt_d = '0;
      clk_d = 1'b0;
      run_d = 1'b0;
      if (pend_q) begin
        hp_d   = hp_pend_q;
        pend_d = 1'b0;
      end
      if (wr_i) begin
        hp_pend_d = wr_hp_i;
        pend_d    = 1'b1;
      end
    end else if (!run_q) begin
      // Start (enable or reset release): high phase begins immediately.
      cnt_d  = '0;
      clk_d  = 1'b1;
      tick_d = 1'b1;
      run_d  = 1'b1;
      if (wr_i) begin
        hp_pend_d = wr_hp_i;
        pend_d    = 1'b1;
      end
    end else if (bnd) begin
      cnt_d = '0;
      if (apply) begin
        hp_d   = nxt_hp;
        pend_d = 1'b0;
      end
      if (apply && (nxt_hp == '0)) begin
        clk_d = 1'b0;
        run_d = 1'b0;
      end else begin
        clk_d  = ~clk_q;
        tick_d = ~clk_q;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (wr_i) begin
        hp_pend_d = wr_hp_i;
        pend_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      hp_q      <= CNT_W'(RST_HP);
      hp_pend_q <= '0;
      pend_q    <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hp_q      <= hp_d;
      hp_pend_q <= hp_pend_d;
      pend_q    <= pend_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      run_q     <= run_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign busy_o = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent clock dividers / tick generators sharing one write port
// for run-time half-period updates.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int          CNT_W  = CNT_W_DEF,
  parameter int          NUM_CH = 4,
  parameter int unsigned RST_HP = hp_for_hz(1),
  parameter int          CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_hp,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  logic [NUM_CH-1:0] wr_sel;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Indices at or above NUM_CH match no channel and are dropped.
    assign wr_sel[g] = wr_en && (int'(wr_ch) == g);

    clk_div_ch #(
      .CNT_W  (CNT_W),
      .RST_HP (RST_HP)
    ) u_ch (
      .clk_i   (clk_50M),
      .rst_i   (rst),
      .en_i    (en[g]),
      .wr_i    (wr_sel[g]),
      .wr_hp_i (wr_hp),
      .clk_o   (clk_out[g]),
      .tick_o  (tick[g]),
      .busy_o  (busy[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: per-cycle expected {clk_out,tick,busy}
// of channel 0 are queued per scenario and compared as the DUT produces them.
module tb_clk_div_bank;

  localparam int CNT_W  = 28;
  localparam int NUM_CH = 4;
  localparam int RST_HP = 10;

  logic              clk_50M;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              wr_en;
  logic [1:0]        wr_ch;
  logic [CNT_W-1:0]  wr_hp;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] busy;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         ch1_start = 0;
  logic [2:0] sbq[$];

  clk_div_bank #(
    .CNT_W  (CNT_W),
    .NUM_CH (NUM_CH),
    .RST_HP (RST_HP)
  ) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .en      (en),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_hp   (wr_hp),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy)
  );

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  always @(posedge clk_50M) cyc <= cyc + 1;

  task automatic push(input logic c, input logic t, input logic b);
    sbq.push_back({c, t, b});
  endtask

  // A phase of len cycles at level v; a high phase carries the tick on its first cycle.
  task automatic push_phase(input logic v, input int len);
    for (int k = 0; k < len; k++) sbq.push_back({v, (v && (k == 0)), 1'b0});
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_50M);
    n_assert++;
    if (clk_out !== 4'b0) begin n_fail++; $display("FAIL reset_clk_out: got %b want 0000", clk_out); end
    n_assert++;
    if (tick !== 4'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0000", tick); end
    n_assert++;
    if (busy !== 4'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0000", busy); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [2:0] e;
    int n;
    sbq = {};
    push(0, 0, 1);
    push(0, 0, 0);
    for (int p = 0; p < 3; p++) begin push_phase(1, 3); push_phase(0, 3); end
    n = sbq.size();
    en[1] = 1'b1;
    ch1_start = cyc + 1;
    for (int i = 0; i < n; i++) begin
      wr_en = (i == 0); wr_ch = 2'd0; wr_hp = 3;
      if (i == 2) en[0] = 1'b1;
      @(negedge clk_50M);
      e = sbq.pop_front();
      n_assert++;
      if ({clk_out[0], tick[0], busy[0]} !== e) begin
        n_fail++;
        $display("FAIL basic[%0d]: got clk/tick/busy %b want %b", i, {clk_out[0], tick[0], busy[0]}, e);
      end
    end
  endtask

  task automatic test_change();
    logic [2:0] e;
    int n;
    sbq = {};
    push(1, 1, 0);
    push(1, 0, 1);
    push(1, 0, 1);
    push_phase(0, 5); push_phase(1, 5); push_phase(0, 5);
    n = sbq.size();
    for (int i = 0; i < n; i++) begin
      wr_en = (i == 1); wr_ch = 2'd0; wr_hp = 5;
      @(negedge clk_50M);
      e = sbq.pop_front();
      n_assert++;
      if ({clk_out[0], tick[0], busy[0]} !== e) begin
        n_fail++;
        $display("FAIL change[%0d]: got clk/tick/busy %b want %b", i, {clk_out[0], tick[0], busy[0]}, e);
      end
    end
  endtask

  task automatic test_boundary();
    logic [2:0] e;
    int n;
    sbq = {};
    push(1, 1, 0);
    for (int k = 0; k < 4; k++) push(1, 0, 1);
    push_phase(0, 6); push_phase(1, 6);
    push_phase(0, 2); push_phase(1, 2); push_phase(0, 2); push_phase(1, 2); push_phase(0, 2);
    n = sbq.size();
    for (int i = 0; i < n; i++) begin
      wr_en = (i == 1) || (i == 2) || (i == 17);
      wr_ch = 2'd0;
      wr_hp = (i == 1) ? 4 : (i == 2) ? 6 : 2;
      @(negedge clk_50M);
      e = sbq.pop_front();
      n_assert++;
      if ({clk_out[0], tick[0], busy[0]} !== e) begin
        n_fail++;
        $display("FAIL boundary[%0d]: got clk/tick/busy %b want %b", i, {clk_out[0], tick[0], busy[0]}, e);
      end
    end
  endtask

  task automatic test_zero();
    logic [2:0] e;
    int n;
    sbq = {};
    push(1, 1, 0);
    push(1, 0, 1);
    push_phase(0, 7);
    push(0, 0, 1);
    push(0, 0, 0);
    for (int k = 0; k < 4; k++) begin push_phase(1, 1); push_phase(0, 1); end
    n = sbq.size();
    for (int i = 0; i < n; i++) begin
      wr_en = (i == 1) || (i == 9);
      wr_ch = 2'd0;
      wr_hp = (i == 1) ? 0 : 1;
      @(negedge clk_50M);
      e = sbq.pop_front();
      n_assert++;
      if ({clk_out[0], tick[0], busy[0]} !== e) begin
        n_fail++;
        $display("FAIL zero_hp[%0d]: got clk/tick/busy %b want %b", i, {clk_out[0], tick[0], busy[0]}, e);
      end
    end
  endtask

  task automatic test_enable();
    logic [2:0] e;
    logic       exp_c1, exp_t1;
    int n, ph;
    sbq = {};
    push_phase(1, 4); push_phase(0, 4); push_phase(1, 2); push_phase(0, 4);
    push_phase(1, 4); push_phase(0, 4); push_phase(1, 4);
    n = sbq.size();
    for (int i = 0; i < n; i++) begin
      wr_en = (i == 0); wr_ch = 2'd0; wr_hp = 4;
      en[0] = !((i >= 10) && (i <= 13));
      @(negedge clk_50M);
      e = sbq.pop_front();
      n_assert++;
      if ({clk_out[0], tick[0], busy[0]} !== e) begin
        n_fail++;
        $display("FAIL enable[%0d]: got clk/tick/busy %b want %b", i, {clk_out[0], tick[0], busy[0]}, e);
      end
      ph = (cyc - ch1_start) % (2 * RST_HP);
      exp_c1 = (ph < RST_HP);
      exp_t1 = (ph == 0);
      n_assert++;
      if ({clk_out[1], tick[1], busy[1]} !== {exp_c1, exp_t1, 1'b0}) begin
        n_fail++;
        $display("FAIL ch1_free_run[%0d]: got %b want %b", i, {clk_out[1], tick[1], busy[1]}, {exp_c1, exp_t1, 1'b0});
      end
      n_assert++;
      if ({clk_out[3:2], tick[3:2], busy[3:2]} !== 6'b0) begin
        n_fail++;
        $display("FAIL ch23_idle[%0d]: got %b want 000000", i, {clk_out[3:2], tick[3:2], busy[3:2]});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    int n;
    sbq = {};
    push(0, 0, 0);
    push(0, 0, 1);
    push(0, 0, 0);
    push_phase(1, RST_HP); push_phase(0, RST_HP); push_phase(1, RST_HP); push_phase(0, RST_HP);
    n = sbq.size();
    for (int i = 0; i < n; i++) begin
      wr_en = (i == 1); wr_ch = 2'd0; wr_hp = 7;
      rst = (i == 2);
      @(negedge clk_50M);
      e = sbq.pop_front();
      n_assert++;
      if ({clk_out[0], tick[0], busy[0]} !== e) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got clk/tick/busy %b want %b", i, {clk_out[0], tick[0], busy[0]}, e);
      end
      if (i == 2) begin
        n_assert++;
        if ({clk_out, tick, busy} !== 12'b0) begin
          n_fail++;
          $display("FAIL reset_mid_all: got %b want all zero", {clk_out, tick, busy});
        end
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = '0;
    wr_en = 1'b0;
    wr_ch = '0;
    wr_hp = '0;
    test_reset();
    test_basic();
    test_change();
    test_boundary();
    test_zero();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
